// File: rtl/path_probe_checker.sv
// path_probe_checker: LFSR probe launcher/capture comparer; PATH_PROBE_FIRST_ERR_EN adds first_err_idx
module path_probe_checker #(
  parameter logic [7:0] SEED    = 8'hA5,
  parameter int         MAX_LAT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] latency,
  input  logic [7:0] len,
  output logic       launch,
  input  logic       capture,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_cnt,
  output logic       pass
`ifdef PATH_PROBE_FIRST_ERR_EN
  ,
  output logic [7:0] first_err_idx
`endif
);
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;
  localparam logic [7:0] SEED_E = (SEED == 8'd0) ? 8'h01 : SEED;
  state_t state, nxt;
  logic [7:0] lfsr, cnt, err_nxt;
  logic [3:0] lat, lat_c;
  logic [MAX_LAT-1:0] exp_bit, vld;
  logic mis, cmp;
  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction
  assign lat_c = (latency == 4'd0) ? 4'd1 : (int'(latency) > MAX_LAT) ? 4'(MAX_LAT) : latency;
  assign busy = (state == SEND) || (state == DRAIN);
  assign done = (state == DONE);
  assign cmp = busy && vld[lat - 4'd1];
  assign mis = cmp && (exp_bit[lat - 4'd1] != capture);
  assign err_nxt = (mis && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  always_comb begin
    nxt = state == IDLE  ? (start ? SEND : IDLE) :
          state == SEND  ? (cnt == 8'd0 ? DRAIN : SEND) :
          state == DRAIN ? (cnt == 8'd0 ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= SEED_E;
      launch  <= 1'b0;
      err_cnt <= 8'd0;
      pass    <= 1'b0;
      vld     <= '0;
      exp_bit <= '0;
      cnt     <= 8'd0;
      lat     <= 4'd1;
    end else begin
      exp_bit <= {exp_bit[MAX_LAT-2:0], launch};
      vld     <= {vld[MAX_LAT-2:0], state == SEND};
      err_cnt <= err_nxt;
      if (state == IDLE && start) begin
        lfsr    <= step(SEED_E);
        launch  <= SEED_E[0];
        err_cnt <= 8'd0;
        pass    <= 1'b0;
        vld     <= '0;
        cnt     <= len - 8'd1;
        lat     <= lat_c;
      end else if (state == SEND) begin
        launch <= (cnt != 8'd0) && lfsr[0];
        lfsr   <= step(lfsr);
        cnt    <= (cnt == 8'd0) ? {4'd0, lat} - 8'd1 : cnt - 8'd1;
      end else if (state == DRAIN) begin
        cnt <= cnt - 8'd1;
        if (cnt == 8'd0) pass <= (err_nxt == 8'd0);
      end
    end
  end
`ifdef PATH_PROBE_FIRST_ERR_EN
  logic [7:0] cmp_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_idx <= 8'd0;
      cmp_idx       <= 8'd0;
    end else if (state == IDLE && start) begin
      first_err_idx <= 8'hFF;
      cmp_idx       <= 8'd0;
    end else if (cmp) begin
      cmp_idx <= cmp_idx + 8'd1;
      if (mis && first_err_idx == 8'hFF) first_err_idx <= cmp_idx;
    end
  end
`endif
endmodule
